line_burst_adaptor: RTL

- Sits directly downstream of the I/D memory arbiter, between the arbiter's 256-bit cacheline port and the 64-bit burst physical memory.
- Converts each whole-line read or write request into a 4-beat burst.
- Reassembles read beats into a line and returns a single-cycle line response to the arbiter.

---
 rtl/line_burst_adaptor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/line_burst_adaptor.sv
// Bridges a 256-bit cacheline request port onto a 64-bit, 4-beat burst memory.
// Read beats are assembled off to the side and published as a whole line on the last beat.
module line_burst_adaptor #(
    parameter int BEAT_WIDTH = 64,
    parameter int NUM_BEATS  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            line_addr_i,
    input  logic                             line_read_i,
    input  logic                             line_write_i,
    input  logic [BEAT_WIDTH*NUM_BEATS-1:0]  line_wdata_i,
    output logic [BEAT_WIDTH*NUM_BEATS-1:0]  line_rdata_o,
    output logic                             line_resp_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic                             mem_read_o,
    output logic                             mem_write_o,
    output logic [BEAT_WIDTH-1:0]            mem_wdata_o,
    input  logic [BEAT_WIDTH-1:0]            mem_rdata_i,
    input  logic                             mem_resp_i
);

    localparam int CNT_WIDTH = $clog2(NUM_BEATS);
    localparam int OFFSET    = $clog2(BEAT_WIDTH * NUM_BEATS / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t                                 state;
    state_t                                 state_next;
    logic [CNT_WIDTH-1:0]                   cnt;
    logic [ADDR_WIDTH-1:0]                  addr_q;
    logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0]   wdata_q;
    logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0]   rbuf;
    logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0]   rbuf_merged;
    logic                                   last_beat;
    logic [ADDR_WIDTH-1:0]                  addr_aligned;

    assign last_beat    = (cnt == CNT_WIDTH'(NUM_BEATS - 1));
    assign addr_aligned = {addr_q[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};

    // The incoming beat merged into the staging buffer, so the final beat can publish a full line.
    always_comb begin
        rbuf_merged      = rbuf;
        rbuf_merged[cnt] = mem_rdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf         <= '0;
            line_rdata_o <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (line_write_i) begin
                        addr_q  <= line_addr_i;
                        wdata_q <= line_wdata_i;
                        cnt     <= '0;
                    end else if (line_read_i) begin
                        addr_q <= line_addr_i;
                        cnt    <= '0;
                    end
                end
                RD_BURST: begin
                    if (mem_resp_i) begin
                        rbuf <= rbuf_merged;
                        cnt  <= cnt + 1'b1;
                        if (last_beat) begin
                            line_rdata_o <= rbuf_merged;
                        end
                    end
                end
                WR_BURST: begin
                    if (mem_resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        line_resp_o = 1'b0;
        mem_wdata_o = '0;
        mem_addr_o  = '0;
        case (state)
            IDLE: begin
                if (line_write_i) begin
                    state_next = WR_BURST;
                end else if (line_read_i) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                mem_read_o = 1'b1;
                mem_addr_o = addr_aligned;
                if (mem_resp_i && last_beat) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                line_resp_o = 1'b1;
                mem_addr_o  = addr_aligned;
                state_next  = IDLE;
            end
            WR_BURST: begin
                mem_write_o = 1'b1;
                mem_wdata_o = wdata_q[cnt];
                mem_addr_o  = addr_aligned;
                if (mem_resp_i && last_beat) begin
                    state_next = WR_DONE;
                end
            end
            WR_DONE: begin
                line_resp_o = 1'b1;
                mem_addr_o  = addr_aligned;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
